// File: rtl/sort_stream_adapter.sv
// Stream-to-block adapter around an external parallel sorter: collects SIZE
// elements, waits SORT_LATENCY cycles for the sorter, then replays its result.
module sort_stream_adapter #(
  parameter int VALUE_BITS   = 8,
  parameter int DEPTH        = 3,
  parameter int SORT_LATENCY = 1,
  localparam int SIZE        = 1 << DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [VALUE_BITS-1:0]               s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [VALUE_BITS-1:0]               m_data,
  output logic                                m_last,
  output logic [SIZE-1:0][VALUE_BITS-1:0]     sort_in,
  input  logic [SIZE-1:0][VALUE_BITS-1:0]     sort_out
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam int WW = $clog2(SORT_LATENCY + 1) + 1;

  typedef enum logic [1:0] {FILL = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [CW-1:0]                      idx_q, idx_d;
  logic [WW-1:0]                      wcnt_q, wcnt_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]    sort_in_q, sort_in_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]    obuf_q, obuf_d;
  logic                               s_ready_q, s_ready_d;
  logic                               m_valid_q, m_valid_d;
  logic [VALUE_BITS-1:0]              m_data_q, m_data_d;
  logic                               m_last_q, m_last_d;

  // Next-state logic; outputs are derived from the next state so they are registered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    sort_in_d = sort_in_q;
    obuf_d    = obuf_q;
    case (state_q)
      FILL: begin
        if (s_valid && s_ready_q) begin
          sort_in_d[cnt_q[DEPTH-1:0]] = s_data;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SIZE - 1)) begin
            state_d = WAIT;
            wcnt_d  = WW'(0);
          end else begin
            state_d = FILL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      WAIT: begin
        if (wcnt_q == WW'(SORT_LATENCY)) begin
          obuf_d  = sort_out;
          idx_d   = CW'(0);
          wcnt_d  = WW'(0);
          state_d = DRAIN;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (idx_q == CW'(SIZE - 1)) begin
            idx_d   = CW'(0);
            cnt_d   = CW'(0);
            state_d = FILL;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = CW'(0);
        idx_d   = CW'(0);
        wcnt_d  = WW'(0);
      end
    endcase
    s_ready_d = (state_d == FILL);
    m_valid_d = (state_d == DRAIN);
    m_data_d  = obuf_d[idx_d[DEPTH-1:0]];
    m_last_d  = (state_d == DRAIN) && (idx_d == CW'(SIZE - 1));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= CW'(0);
      idx_q     <= CW'(0);
      wcnt_q    <= WW'(0);
      sort_in_q <= '0;
      obuf_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      sort_in_q <= sort_in_d;
      obuf_q    <= obuf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign sort_in = sort_in_q;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Scoreboard bench: three adapters (sorter latency 1, 3, 5) each fed by an
// ascending model sorter; instance 0 carries the main traffic.
module tb_sort_stream_adapter;

  localparam int VB = 8;
  localparam int SZ = 8;
  typedef logic [SZ-1:0][VB-1:0] blk_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sv [3];
  logic [VB-1:0] sd [3];
  logic          mr [3];
  wire           sr [3];
  wire           mv [3];
  wire           ml [3];
  wire  [VB-1:0] md [3];
  wire  blk_t    sin [3];
  wire  blk_t    sout [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];
  int xfers       = 0;
  int blocks_sent = 0;
  int blocks_done = 0;

  function automatic blk_t sort_blk(input blk_t x);
    blk_t r;
    logic [VB-1:0] t;
    r = x;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ - 1 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
    blk_t pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= sort_blk(sin[g]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sout[g] = pipe[LAT-1];
    sort_stream_adapter #(.VALUE_BITS(VB), .DEPTH(3), .SORT_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(sv[g]), .s_ready(sr[g]), .s_data(sd[g]),
      .m_valid(mv[g]), .m_ready(mr[g]), .m_data(md[g]), .m_last(ml[g]),
      .sort_in(sin[g]), .sort_out(sout[g])
    );
  end

  // Output monitor for instance 0: scoreboard pop, stall hold, s_ready while busy
  logic          stall_r = 1'b0;
  logic [VB-1:0] held_d  = '0;
  logic          held_l  = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_r) begin
        check_value("hold_valid", 32'(mv[0]), 32'd1);
        check_value("hold_data", 32'(md[0]), 32'(held_d));
        check_value("hold_last", 32'(ml[0]), 32'(held_l));
      end
      if (blocks_sent != blocks_done)
        check_value("s_ready_busy", 32'(sr[0]), 32'd0);
      if (mv[0] && mr[0]) begin
        check_value("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_value("m_data", 32'(md[0]), 32'(exp_q[0][7:0]));
          check_value("m_last", 32'(ml[0]), 32'(exp_q[0][8]));
          if (exp_q[0][8]) blocks_done <= blocks_done + 1;
          void'(exp_q.pop_front());
        end
        xfers <= xfers + 1;
      end
      stall_r <= mv[0] && !mr[0];
      held_d  <= md[0];
      held_l  <= ml[0];
    end else begin
      stall_r <= 1'b0;
    end
  end

  task automatic send(input logic [VB-1:0] v [SZ], input int n, input int duty);
    logic hs;
    int   t;
    blk_t s;
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        sv[0] = ($urandom_range(99) < duty);
        sd[0] = v[k];
        @(negedge clk);
        hs = sv[0] && sr[0];
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 300);
      if (!hs) check_value("hs_timeout", 32'(hs), 32'd1);
    end
    sv[0] = 1'b0;
    if (n == SZ) begin
      for (int k = 0; k < SZ; k++) begin
        check_value("sort_in_order", 32'(sin[0][k]), 32'(v[k]));
        s[k] = v[k];
      end
      s = sort_blk(s);
      for (int k = 0; k < SZ; k++) exp_q.push_back({(k == SZ - 1), s[k]});
      blocks_sent++;
    end
  endtask

  task automatic wait_done(input logic bp);
    logic pat [4];
    int   t;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      if (bp) mr[0] = pat[t % 4];
      @(posedge clk);
      #1;
      t++;
    end
    mr[0] = 1'b1;
    check_value("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_blk(output logic [VB-1:0] v [SZ]);
    for (int k = 0; k < SZ; k++) v[k] = VB'($urandom_range(255));
  endtask

  initial begin
    logic [VB-1:0] blk [SZ];
    int n, x0, f1, f2;
    logic [VB-1:0] d1, d2;
    for (int g = 0; g < 3; g++) begin
      sv[g] = 1'b0; sd[g] = '0; mr[g] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_s_ready", 32'(sr[0]), 32'd0);
    check_value("rst_m_valid", 32'(mv[0]), 32'd0);
    check_value("rst_m_last", 32'(ml[0]), 32'd0);
    check_value("rst_sort_in", 32'(sin[0] != '0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("first_s_ready", 32'(sr[0]), 32'd1);

    // basic block and first-valid latency
    blk = '{8'd7, 8'd3, 8'd5, 8'd0, 8'd6, 8'd1, 8'd4, 8'd2};
    send(blk, SZ, 100);
    n = 0;
    while (!mv[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("lat1_first_valid", 32'(n), 32'd2);
    wait_done(1'b0);

    // backpressure
    rand_blk(blk);
    x0 = xfers;
    send(blk, SZ, 100);
    wait_done(1'b1);
    check_value("bp_xfers", 32'(xfers - x0), 32'd8);
    check_value("bp_s_ready", 32'(sr[0]), 32'd1);

    // upstream gaps
    for (int r = 0; r < 2; r++) begin
      rand_blk(blk);
      send(blk, SZ, 50);
      wait_done(1'b0);
    end

    // back-to-back, including duplicates
    blk = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd9, 8'd9};
    send(blk, SZ, 100);
    rand_blk(blk);
    send(blk, SZ, 100);
    blk = '{8'd9, 8'd9, 8'd0, 8'd5, 8'd5, 8'd0, 8'd5, 8'd5};
    send(blk, SZ, 100);
    wait_done(1'b0);

    // reset mid-block
    blk = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207};
    send(blk, 4, 100);
    rst_n = 1'b0;
    #2;
    check_value("midrst_m_valid", 32'(mv[0]), 32'd0);
    check_value("midrst_s_ready", 32'(sr[0]), 32'd0);
    check_value("midrst_sort_in", 32'(sin[0] != '0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("midrst_m_valid2", 32'(mv[0]), 32'd0);
    rst_n = 1'b1;
    blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send(blk, SZ, 100);
    wait_done(1'b0);

    // latency sweep on instances 1 (L=3) and 2 (L=5)
    for (int k = 0; k < SZ; k++) begin
      sv[1] = 1'b1; sv[2] = 1'b1;
      sd[1] = VB'(SZ - k); sd[2] = VB'(SZ - k);
      @(negedge clk);
      check_value("sweep_s_ready3", 32'(sr[1]), 32'd1);
      check_value("sweep_s_ready5", 32'(sr[2]), 32'd1);
      @(posedge clk);
      #1;
    end
    sv[1] = 1'b0; sv[2] = 1'b0;
    f1 = 0; f2 = 0; d1 = '0; d2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (mv[1] && f1 == 0) begin f1 = c; d1 = md[1]; end
      if (mv[2] && f2 == 0) begin f2 = c; d2 = md[2]; end
    end
    check_value("lat3_first_valid", 32'(f1), 32'd4);
    check_value("lat5_first_valid", 32'(f2), 32'd6);
    check_value("lat3_first_data", 32'(d1), 32'd1);
    check_value("lat5_first_data", 32'(d2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
